// File: rtl/uart_rx_param.sv
// ---------------------------------------------------------------------------
// uart_rx_param
//   Parameterised oversampling UART receiver with a one-entry holding
//   register and valid/ready handoff to the consumer.
//
//   Each line bit is split into OVERSAMPLE ticks of DIV clocks. The bit value
//   is the majority of the three samples around mid-bit. The FSM releases the
//   line at the last stop-bit decision rather than at the bit end, so a start
//   edge that follows immediately is not missed.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   rx         in   asynchronous serial line, idle high
//   data       out  received word (first bit on the line lands in bit 0)
//   valid      out  data/parity_err/frame_err hold a frame
//   ready      in   consumer takes the held frame when valid && ready
//   parity_err out  parity mismatch for the held frame
//   frame_err  out  a stop bit was decided low for the held frame
//   overrun    out  one-clock pulse: frame dropped, holding register full
//   busy       out  receiver FSM is not idle
// ---------------------------------------------------------------------------
module uart_rx_param #(
    parameter int CLOCK_FREQ = 38400000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);

    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [SW-1:0] SMP_A     = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SMP_B     = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SMP_C     = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] SMP_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // Majority vote of the three mid-bit samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Parity bit the transmitter should have sent for word d.
    function automatic logic par_exp(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~(^d) : (^d);
    endfunction

    // Synchronizer and edge detection
    logic                 sync1_q, sync2_q, rs_prev_q;
    logic [1:0]           fill_q;
    logic                 armed_q;
    logic                 rs;

    // Receiver FSM and bit timing
    state_t               state_q;
    logic [TW-1:0]        tick_q;
    logic [SW-1:0]        samp_q;
    logic [3:0]           bit_q;
    logic                 stop_q;
    logic [1:0]           smp_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_err_q;
    logic                 ferr_q;

    // Holding register
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 perr_out_q;
    logic                 ferr_out_q;
    logic                 ovr_q;

    logic                 start_d, tick_d, decide_d, bit_end_d, done_d;
    logic                 maj_d, ferr_d;
    logic [DATA_BITS-1:0] shift_d;

    assign rs        = sync2_q;
    // armed_q blocks a start until the line has genuinely been seen high after
    // reset; the reset value of the synchronizer does not count.
    assign start_d   = armed_q && rs_prev_q && !rs;
    assign tick_d    = (tick_q == TICK_LAST);
    assign decide_d  = tick_d && (samp_q == SMP_C);
    assign bit_end_d = tick_d && (samp_q == SMP_LAST);
    assign maj_d     = maj3(smp_q[0], smp_q[1], rs);
    assign shift_d   = {maj_d, shift_q[DATA_BITS-1:1]};
    assign ferr_d    = ferr_q | ~maj_d;
    assign done_d    = decide_d && (state_q == ST_STOP) && (stop_q == STOP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rs_prev_q  <= 1'b1;
            fill_q     <= 2'b00;
            armed_q    <= 1'b0;
            state_q    <= ST_IDLE;
            tick_q     <= '0;
            samp_q     <= '0;
            bit_q      <= '0;
            stop_q     <= 1'b0;
            smp_q      <= 2'b11;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            ferr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            sync1_q   <= rx;
            sync2_q   <= sync1_q;
            rs_prev_q <= rs;
            // fill_q[1] marks the first clock on which sync2_q holds a real rx sample.
            fill_q    <= {fill_q[0], 1'b1};
            if (fill_q[1] && rs) begin
                armed_q <= 1'b1;
            end
            ovr_q <= 1'b0;

            // Tick and sample-position counters run only while a frame is in flight.
            if (state_q == ST_IDLE) begin
                tick_q <= '0;
                samp_q <= '0;
            end else if (tick_d) begin
                tick_q <= '0;
                samp_q <= (samp_q == SMP_LAST) ? '0 : samp_q + 1'b1;
                if (samp_q == SMP_A) smp_q[0] <= rs;
                if (samp_q == SMP_B) smp_q[1] <= rs;
            end else begin
                tick_q <= tick_q + 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_d) begin
                        state_q   <= ST_START;
                        bit_q     <= '0;
                        stop_q    <= 1'b0;
                        par_err_q <= 1'b0;
                        ferr_q    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (decide_d && maj_d) begin
                        state_q <= ST_IDLE;  // too short to be a start bit
                    end else if (bit_end_d) begin
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (decide_d) begin
                        shift_q <= shift_d;
                    end
                    if (bit_end_d) begin
                        if (bit_q == BIT_LAST) begin
                            state_q <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (decide_d) begin
                        par_err_q <= (maj_d != par_exp(shift_q));
                    end
                    if (bit_end_d) begin
                        state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (decide_d) begin
                        ferr_q <= ferr_d;
                        if (stop_q == STOP_LAST) begin
                            state_q <= ST_IDLE;
                        end
                    end else if (bit_end_d) begin
                        stop_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Handoff: a finished frame is stored if the slot is free or being
            // emptied this clock; otherwise it is dropped and flagged.
            if (done_d) begin
                if (!valid_q || ready) begin
                    data_q     <= shift_q;
                    perr_out_q <= par_err_q;
                    ferr_out_q <= ferr_d;
                    valid_q    <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_out_q;
    assign frame_err  = ferr_out_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_param
//   Two receivers on one clock: dut_a is 8N1, dut_b is 8 data bits, even
//   parity, two stop bits. Both run with 4 clocks per tick (64 clocks/bit).
//   Frames are driven bit by bit; expected words and flags are computed from
//   the bits put on the line.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_param;

    localparam int BAUD     = 9600;
    localparam int OS       = 16;
    localparam int DIV      = 4;
    localparam int CLK_HZ   = BAUD * OS * DIV;
    localparam int BIT_CLKS = DIV * OS;
    localparam int M        = OS / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_a = 1'b1, ready_a = 1'b1;
    logic       rx_b = 1'b1, ready_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic       valid_a, perr_a, ferr_a, ovr_a, busy_a;
    logic       valid_b, perr_b, ferr_b, ovr_b, busy_b;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_param #(
        .CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(OS)
    ) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .data(data_a), .valid(valid_a),
        .ready(ready_a), .parity_err(perr_a), .frame_err(ferr_a),
        .overrun(ovr_a), .busy(busy_a)
    );

    uart_rx_param #(
        .CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(2), .OVERSAMPLE(OS)
    ) dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .data(data_b), .valid(valid_b),
        .ready(ready_b), .parity_err(perr_b), .frame_err(ferr_b),
        .overrun(ovr_b), .busy(busy_b)
    );

    // Consumer-side monitors: every accepted frame, valid-high cycles,
    // the cycle of the last valid rise and overrun pulse cycles.
    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } rec_t;

    rec_t qa[$];
    rec_t qb[$];
    int   vcyc_a = 0, vcyc_b = 0, rise_a = -1, rise_b = -1;
    int   ovr_cnt_a = 0, ovr_cnt_b = 0;
    logic vprev_a = 1'b0, vprev_b = 1'b0;

    always @(negedge clk) begin
        if (valid_a && ready_a) qa.push_back('{d: data_a, pe: perr_a, fe: ferr_a});
        if (valid_a) vcyc_a <= vcyc_a + 1;
        if (valid_a && !vprev_a) rise_a <= cyc;
        if (ovr_a) ovr_cnt_a <= ovr_cnt_a + 1;
        vprev_a <= valid_a;
        if (valid_b && ready_b) qb.push_back('{d: data_b, pe: perr_b, fe: ferr_b});
        if (valid_b) vcyc_b <= vcyc_b + 1;
        if (valid_b && !vprev_b) rise_b <= cyc;
        if (ovr_b) ovr_cnt_b <= ovr_cnt_b + 1;
        vprev_b <= valid_b;
    end

    // Expected valid rise: start edge + 2 synchronizer clocks, tick n of the
    // frame lands (n+1)*DIV clocks after detection, valid registers 1 clock later.
    function automatic int exp_rise(input int t0, input int last_stop_idx);
        int n;
        n = last_stop_idx * OS + M + 1;
        return t0 + 3 + (n + 1) * DIV;
    endfunction

    task automatic drive_bit(input int which, input logic v);
        if (which == 0) rx_a = v; else rx_b = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    // Sends one frame; dut_b frames carry the parity bit and a second stop bit.
    task automatic drive_frame(input int which, input logic [7:0] d, input logic pbit,
                               input logic s0, input logic s1, output int t0);
        t0 = cyc;
        drive_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
        if (which == 1) drive_bit(which, pbit);
        drive_bit(which, s0);
        if (which == 1) drive_bit(which, s1);
        if (which == 0) rx_a = 1'b1; else rx_b = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_a = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({valid_a, perr_a, ferr_a, ovr_a, busy_a} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags_a: got %b want 00000", {valid_a, perr_a, ferr_a, ovr_a, busy_a});
        end
        n_checks++;
        if (data_a !== 8'h00) begin
            n_fail++; $display("FAIL reset_data_a: got %h want 00", data_a);
        end
        n_checks++;
        if ({valid_b, perr_b, ferr_b, ovr_b, busy_b, data_b} !== 13'b0) begin
            n_fail++; $display("FAIL reset_all_b: got %b want 0", {valid_b, perr_b, ferr_b, ovr_b, busy_b, data_b});
        end
        rst = 1'b0;
        repeat (2 * BIT_CLKS) @(negedge clk);
        n_checks++;
        if (busy_a !== 1'b0) begin
            n_fail++; $display("FAIL low_release_busy: got %b want 0", busy_a);
        end
        n_checks++;
        if (qa.size() !== 0 || valid_a !== 1'b0) begin
            n_fail++; $display("FAIL low_release_valid: frames %0d valid %b want 0 0", qa.size(), valid_a);
        end
        rx_a = 1'b1;
        repeat (BIT_CLKS / 2) @(negedge clk);
    endtask

    task automatic test_basic();
        int   t0, v0;
        rec_t r;
        v0 = vcyc_a;
        drive_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1, t0);
        repeat (BIT_CLKS / 2) @(negedge clk);
        n_checks++;
        if (qa.size() !== 1) begin
            n_fail++; $display("FAIL basic_count: got %0d want 1", qa.size());
        end else begin
            r = qa.pop_front();
            n_checks++;
            if (r !== {8'hA5, 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL basic_frame: got d=%h pe=%b fe=%b want d=a5 pe=0 fe=0", r.d, r.pe, r.fe);
            end
            n_checks++;
            if (vcyc_a - v0 !== 1) begin
                n_fail++; $display("FAIL basic_valid_len: got %0d want 1", vcyc_a - v0);
            end
            n_checks++;
            if (rise_a < exp_rise(t0, 9) - 2 || rise_a > exp_rise(t0, 9) + 2) begin
                n_fail++; $display("FAIL basic_latency: got %0d want %0d", rise_a - t0, exp_rise(t0, 9) - t0);
            end
        end
    endtask

    task automatic test_parity();
        logic [7:0] d_tab[3];
        logic       p_tab[3];
        int         t0;
        rec_t       r;
        logic       pe;
        d_tab = '{8'h03, 8'h03, 8'h07};
        p_tab = '{1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            pe = (p_tab[k] != ^d_tab[k]);
            drive_frame(1, d_tab[k], p_tab[k], 1'b1, 1'b1, t0);
            repeat (BIT_CLKS / 2) @(negedge clk);
            n_checks++;
            if (qb.size() !== 1) begin
                n_fail++; $display("FAIL parity_count[%0d]: got %0d want 1", k, qb.size());
            end else begin
                r = qb.pop_front();
                n_checks++;
                if (r !== {d_tab[k], pe, 1'b0}) begin
                    n_fail++; $display("FAIL parity_frame[%0d]: got d=%h pe=%b fe=%b want d=%h pe=%b fe=0", k, r.d, r.pe, r.fe, d_tab[k], pe);
                end
                n_checks++;
                if (rise_b < exp_rise(t0, 11) - 2 || rise_b > exp_rise(t0, 11) + 2) begin
                    n_fail++; $display("FAIL parity_latency[%0d]: got %0d want %0d", k, rise_b - t0, exp_rise(t0, 11) - t0);
                end
            end
        end
    endtask

    task automatic test_frame_err();
        int   t0;
        rec_t r;
        drive_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, t0);
        repeat (BIT_CLKS / 2) @(negedge clk);
        n_checks++;
        if (qa.size() !== 1) begin
            n_fail++; $display("FAIL ferr_count: got %0d want 1", qa.size());
        end else begin
            r = qa.pop_front();
            n_checks++;
            if (r !== {8'h5A, 1'b0, 1'b1}) begin
                n_fail++; $display("FAIL ferr_frame: got d=%h pe=%b fe=%b want d=5a pe=0 fe=1", r.d, r.pe, r.fe);
            end
        end
    endtask

    task automatic test_overrun();
        int   t0, o0;
        rec_t r;
        @(posedge clk); #1 ready_a = 1'b0;
        o0 = ovr_cnt_a;
        drive_frame(0, 8'h11, 1'b0, 1'b1, 1'b1, t0);
        drive_frame(0, 8'h22, 1'b0, 1'b1, 1'b1, t0);
        repeat (BIT_CLKS / 2) @(negedge clk);
        n_checks++;
        if (ovr_cnt_a - o0 !== 1) begin
            n_fail++; $display("FAIL overrun_pulses: got %0d want 1", ovr_cnt_a - o0);
        end
        n_checks++;
        if ({valid_a, data_a, perr_a, ferr_a} !== {1'b1, 8'h11, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL overrun_hold: got v=%b d=%h pe=%b fe=%b want v=1 d=11 pe=0 fe=0", valid_a, data_a, perr_a, ferr_a);
        end
        @(posedge clk); #1 ready_a = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (valid_a !== 1'b0) begin
            n_fail++; $display("FAIL overrun_drain_clear: got %b want 0", valid_a);
        end
        n_checks++;
        if (qa.size() !== 1) begin
            n_fail++; $display("FAIL overrun_drain_count: got %0d want 1", qa.size());
        end else begin
            r = qa.pop_front();
            n_checks++;
            if (r.d !== 8'h11) begin
                n_fail++; $display("FAIL overrun_drain_data: got %h want 11", r.d);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_glitch();
        int v0;
        v0 = vcyc_a;
        rx_a = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        rx_a = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++;
        if (busy_a !== 1'b1) begin
            n_fail++; $display("FAIL glitch_busy_seen: got %b want 1", busy_a);
        end
        repeat (BIT_CLKS - 3 * DIV - 6) @(negedge clk);
        n_checks++;
        if (busy_a !== 1'b0) begin
            n_fail++; $display("FAIL glitch_busy_drop: got %b want 0", busy_a);
        end
        repeat (BIT_CLKS) @(negedge clk);
        n_checks++;
        if (vcyc_a - v0 !== 0 || qa.size() !== 0) begin
            n_fail++; $display("FAIL glitch_no_valid: got %0d valid cycles want 0", vcyc_a - v0);
        end
    endtask

    task automatic test_break();
        rec_t r;
        rx_a = 1'b0;
        repeat (12 * BIT_CLKS) @(negedge clk);
        n_checks++;
        if (qa.size() !== 1) begin
            n_fail++; $display("FAIL break_count: got %0d want 1", qa.size());
        end else begin
            r = qa.pop_front();
            n_checks++;
            if (r !== {8'h00, 1'b0, 1'b1}) begin
                n_fail++; $display("FAIL break_frame: got d=%h pe=%b fe=%b want d=00 pe=0 fe=1", r.d, r.pe, r.fe);
            end
        end
        n_checks++;
        if (busy_a !== 1'b0) begin
            n_fail++; $display("FAIL break_no_restart: got busy %b want 0", busy_a);
        end
        rx_a = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        n_checks++;
        if (qa.size() !== 0 || busy_a !== 1'b0) begin
            n_fail++; $display("FAIL break_idle_after: frames %0d busy %b want 0 0", qa.size(), busy_a);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        int         t0, o0, v0;
        rec_t       r;
        d = 8'h33;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(0, d[i]);
        rx_a = d[3];
        repeat (BIT_CLKS / 2) @(negedge clk);
        n_checks++;
        if (busy_a !== 1'b1) begin
            n_fail++; $display("FAIL midframe_busy: got %b want 1", busy_a);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({valid_a, perr_a, ferr_a, ovr_a, busy_a, data_a} !== 13'b0) begin
            n_fail++; $display("FAIL midframe_reset_outputs: got %b want 0", {valid_a, perr_a, ferr_a, ovr_a, busy_a, data_a});
        end
        o0 = ovr_cnt_a;
        v0 = vcyc_a;
        rst = 1'b0;
        rx_a = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        n_checks++;
        if (vcyc_a - v0 !== 0 || ovr_cnt_a - o0 !== 0 || qa.size() !== 0) begin
            n_fail++; $display("FAIL midframe_abort: valid cycles %0d overruns %0d want 0 0", vcyc_a - v0, ovr_cnt_a - o0);
        end
        drive_frame(0, 8'hC3, 1'b0, 1'b1, 1'b1, t0);
        repeat (BIT_CLKS / 2) @(negedge clk);
        n_checks++;
        if (qa.size() !== 1) begin
            n_fail++; $display("FAIL midframe_next_count: got %0d want 1", qa.size());
        end else begin
            r = qa.pop_front();
            n_checks++;
            if (r !== {8'hC3, 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL midframe_next_frame: got d=%h pe=%b fe=%b want d=c3 pe=0 fe=0", r.d, r.pe, r.fe);
            end
        end
    endtask

    task automatic test_random_a();
        logic [7:0] d;
        logic       s0;
        int         t0, gap;
        rec_t       r;
        for (int k = 0; k < 10; k++) begin
            d   = 8'($urandom);
            s0  = ($urandom_range(0, 3) != 0);
            gap = $urandom_range(2, 40);
            drive_frame(0, d, 1'b0, s0, 1'b1, t0);
            repeat (gap) @(negedge clk);
            n_checks++;
            if (qa.size() !== 1) begin
                n_fail++; $display("FAIL rand_a_count[%0d]: got %0d want 1", k, qa.size());
            end else begin
                r = qa.pop_front();
                n_checks++;
                if (r !== {d, 1'b0, ~s0}) begin
                    n_fail++; $display("FAIL rand_a_frame[%0d]: got d=%h pe=%b fe=%b want d=%h pe=0 fe=%b", k, r.d, r.pe, r.fe, d, ~s0);
                end
                n_checks++;
                if (rise_a < exp_rise(t0, 9) - 2 || rise_a > exp_rise(t0, 9) + 2) begin
                    n_fail++; $display("FAIL rand_a_latency[%0d]: got %0d want %0d", k, rise_a - t0, exp_rise(t0, 9) - t0);
                end
            end
        end
    endtask

    task automatic test_random_b();
        logic [7:0] d;
        logic       pbit, s0, s1, pe, fe;
        int         t0, gap;
        rec_t       r;
        for (int k = 0; k < 8; k++) begin
            d    = 8'($urandom);
            pbit = 1'($urandom);
            s0   = ($urandom_range(0, 3) != 0);
            s1   = ($urandom_range(0, 3) != 0);
            gap  = $urandom_range(2, 40);
            pe   = (pbit != ^d);
            fe   = !(s0 && s1);
            drive_frame(1, d, pbit, s0, s1, t0);
            repeat (gap) @(negedge clk);
            n_checks++;
            if (qb.size() !== 1) begin
                n_fail++; $display("FAIL rand_b_count[%0d]: got %0d want 1", k, qb.size());
            end else begin
                r = qb.pop_front();
                n_checks++;
                if (r !== {d, pe, fe}) begin
                    n_fail++; $display("FAIL rand_b_frame[%0d]: got d=%h pe=%b fe=%b want d=%h pe=%b fe=%b", k, r.d, r.pe, r.fe, d, pe, fe);
                end
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_overrun();
        test_glitch();
        test_break();
        test_reset_midframe();
        test_random_a();
        test_random_b();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
